// File: rtl/downselect_mask_ctrl.sv
// downselect_mask_ctrl
//
// Host-facing staging memory for a 2048-channel downselect mask plus a
// small controller that replays the whole mask, one 32-bit word per
// handshake, into the downselect select port.
//
// Flow: the host writes words into the staging memory while IDLE, then
// pulses cfg_commit.  The controller moves to ARMED, then to STREAM, and
// streams words 0..MASK_WORDS-1 before returning to IDLE and bumping
// load_count.  The staging memory is never cleared, so a commit with no
// new writes replays the previous mask.
//
// Build option:
//   DSEL_COMMIT_ON_EOB_EN  defined   -> ARMED waits for eob_tag so that the
//                                       mask only changes at a burst boundary.
//                          undefined -> ARMED moves to STREAM on the next
//                                       cycle and eob_tag is ignored.
//
// Handshake on m_axis_select_*: a word transfers on a rising edge where
// tvalid and tready are both high.  tvalid/tdata/tlast come straight from
// registers, never depend combinationally on tready, and stay unchanged
// while tvalid is high and tready is low.  tvalid only drops between
// words when the previous word has just been accepted and the next one
// is not yet loaded, or after the last word.
//
// dbg_state exposes the controller state for checkers:
//   2'd0 IDLE, 2'd1 ARMED, 2'd2 STREAM.

module downselect_mask_ctrl #(
  parameter int MASK_WORDS = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              sync_reset,

  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  logic [31:0]       cfg_wr_data,
  input  logic              cfg_commit,

  input  logic              eob_tag,

  output logic              m_axis_select_tvalid,
  output logic [31:0]       m_axis_select_tdata,
  output logic              m_axis_select_tlast,
  input  logic              m_axis_select_tready,

  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       load_count,
  output logic [1:0]        dbg_state
);

  // Controller states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Index of the final word of a load; that word carries tlast.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MASK_WORDS - 1);

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic [1:0]        state;
  logic [1:0]        state_nxt;

  // Staging memory: intentionally not reset, contents persist across loads.
  logic [31:0]       stage_mem [MASK_WORDS];

  // Index of the next word to be loaded into the output register.
  logic [ADDR_W-1:0] rd_idx;

  logic [31:0]       wr_addr_ext;
  logic              addr_ok;
  logic              is_idle;
  logic              is_stream;
  logic              wr_accept;
  logic              wr_reject;
  logic              commit_accept;
  logic              commit_reject;
  logic              out_hs;
  logic              last_hs;
  logic              load_word;
  logic              arm_go;

  // ---------------------------------------------------------------------
  // Host-side decode
  // ---------------------------------------------------------------------
  assign wr_addr_ext   = 32'(cfg_wr_addr);
  assign addr_ok       = (wr_addr_ext < 32'(MASK_WORDS));

  assign is_idle       = (state == ST_IDLE);
  assign is_stream     = (state == ST_STREAM);

  // A write in the same cycle as an accepted commit still lands, because
  // the controller is IDLE on that edge; the stream starts two or more
  // cycles later and therefore reads the new word.
  assign wr_accept     = cfg_wr_en &  is_idle & addr_ok;
  assign wr_reject     = cfg_wr_en & ~(is_idle & addr_ok);
  assign commit_accept = cfg_commit &  is_idle;
  assign commit_reject = cfg_commit & ~is_idle;

  // ---------------------------------------------------------------------
  // Stream-side decode
  // ---------------------------------------------------------------------
  assign out_hs  = m_axis_select_tvalid & m_axis_select_tready;
  assign last_hs = out_hs & m_axis_select_tlast;

  // Refill the output register when it is empty, or when its current word
  // is leaving and it is not the last one.  Once the last word is loaded
  // nothing else is fetched, so no word can be emitted twice.
  assign load_word = is_stream &
                     (~m_axis_select_tvalid |
                      (m_axis_select_tready & ~m_axis_select_tlast));

  // Permission to leave ARMED.
`ifdef DSEL_COMMIT_ON_EOB_EN
  assign arm_go = eob_tag;
`else
  logic unused_eob_tag;
  assign unused_eob_tag = eob_tag;
  assign arm_go         = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // Combinational next-state selection for the IDLE/ARMED/STREAM controller.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (commit_accept) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (arm_go) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_hs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE and aborts any load in flight.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Staging memory
  // ---------------------------------------------------------------------
  // Host writes land only while IDLE and in range; the array has no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      stage_mem[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Output register and word index
  // ---------------------------------------------------------------------
  // Registered stream output: fetch, hold under backpressure, retire.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      m_axis_select_tvalid <= 1'b0;
      m_axis_select_tdata  <= 32'd0;
      m_axis_select_tlast  <= 1'b0;
      rd_idx               <= '0;
    end else if (!is_stream) begin
      // Outside STREAM the port is quiet and the next load starts at word 0.
      m_axis_select_tvalid <= 1'b0;
      m_axis_select_tlast  <= 1'b0;
      rd_idx               <= '0;
    end else if (load_word) begin
      m_axis_select_tvalid <= 1'b1;
      m_axis_select_tdata  <= stage_mem[rd_idx];
      m_axis_select_tlast  <= (rd_idx == LAST_IDX);
      rd_idx               <= rd_idx + ADDR_W'(1);
    end else if (last_hs) begin
      m_axis_select_tvalid <= 1'b0;
      m_axis_select_tlast  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------
  // Completed-load counter (wraps naturally) and one-cycle reject pulse.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      load_count <= 16'd0;
      cfg_err    <= 1'b0;
    end else begin
      if (last_hs) begin
        load_count <= load_count + 16'd1;
      end
      cfg_err <= wr_reject | commit_reject;
    end
  end

  assign busy      = ~is_idle;
  assign dbg_state = state;

endmodule

// File: tb/tb_downselect_mask_ctrl.sv
// tb_downselect_mask_ctrl
//
// Directed sequence with randomized data and randomized tready.  The
// reference model is a plain array holding what the staging memory should
// contain; each commit snapshots it into an expected queue that the
// stream must drain in order.

module tb_downselect_mask_ctrl;

  localparam int MW = 64;
  localparam int AW = 7;

  // Clock / reset
  logic          clk;
  logic          sync_reset;

  // DUT ports
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [31:0]   cfg_wr_data;
  logic          cfg_commit;
  logic          eob_tag;
  logic          tvalid;
  logic [31:0]   tdata;
  logic          tlast;
  logic          tready;
  logic          busy;
  logic          cfg_err;
  logic [15:0]   load_count;
  logic [1:0]    dbg_state;

  // Scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   model_mem [MW];
  logic [31:0]   exp_q[$];
  int            exp_loads = 0;

  downselect_mask_ctrl #(
    .MASK_WORDS (MW),
    .ADDR_W     (AW)
  ) dut (
    .clk                  (clk),
    .sync_reset           (sync_reset),
    .cfg_wr_en            (cfg_wr_en),
    .cfg_wr_addr          (cfg_wr_addr),
    .cfg_wr_data          (cfg_wr_data),
    .cfg_commit           (cfg_commit),
    .eob_tag              (eob_tag),
    .m_axis_select_tvalid (tvalid),
    .m_axis_select_tdata  (tdata),
    .m_axis_select_tlast  (tlast),
    .m_axis_select_tready (tready),
    .busy                 (busy),
    .cfg_err              (cfg_err),
    .load_count           (load_count),
    .dbg_state            (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One host write (optionally with commit in the same cycle); returns at
  // the next falling edge.  The model only follows writes the DUT should
  // accept (in range; caller only writes while idle).
  task automatic wr(input int addr, input logic [31:0] data, input logic with_commit);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = AW'(addr);
    cfg_wr_data = data;
    cfg_commit  = with_commit;
    @(negedge clk);
    cfg_wr_en   = 1'b0;
    cfg_commit  = 1'b0;
    if (addr < MW) model_mem[addr] = data;
  endtask

  // Snapshot the model into the expected queue for the next load.
  task automatic fill_exp();
    exp_q.delete();
    for (int i = 0; i < MW; i++) exp_q.push_back(model_mem[i]);
  endtask

  // Called one falling edge after an accepted commit: waits out ARMED.
  task automatic arm_and_start();
    chk("busy_after_commit", busy, 1);
`ifdef DSEL_COMMIT_ON_EOB_EN
    for (int i = 0; i < 8; i++) begin
      chk("armed_no_valid", tvalid, 0);
      chk("armed_busy", busy, 1);
      @(negedge clk);
    end
    eob_tag = 1'b1;
    @(negedge clk);
    eob_tag = 1'b0;
`else
    begin
      int w;
      w = 0;
      while (!tvalid && w < 5) begin
        @(negedge clk);
        w++;
      end
      chk("start_without_eob", tvalid, 1);
    end
`endif
  endtask

  // Drain nwords from the stream with tready high pct% of the time.  A
  // commit plus a write are injected at cycle inject_at (0 = never) and
  // must be rejected with a cfg_err pulse.
  task automatic run_stream(input int pct, input int nwords, input int inject_at);
    int          got;
    int          cyc;
    int          err_chk;
    logic        stall;
    logic [31:0] held;
    logic [31:0] exp;
    got = 0; cyc = 0; err_chk = -1; stall = 1'b0; held = '0;
    while (got < nwords && cyc < 3000) begin
      cyc++;
      tready = ($urandom_range(0, 99) < pct);
      if (stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, held);
      end
      if (err_chk > 0 && cyc == err_chk)     chk("busy_err_pulse", cfg_err, 1);
      if (err_chk > 0 && cyc == err_chk + 1) chk("busy_err_clear", cfg_err, 0);
      if (cyc == inject_at) begin
        cfg_commit  = 1'b1;
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = '0;
        cfg_wr_data = 32'hDEAD_BEEF;
        err_chk     = cyc + 1;
      end else begin
        cfg_commit = 1'b0;
        cfg_wr_en  = 1'b0;
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          chk("tdata", tdata, exp);
          chk("tlast", tlast, 32'(got == MW - 1));
        end
        got++;
      end
      stall = tvalid && !tready;
      held  = tdata;
      @(negedge clk);
    end
    cfg_commit = 1'b0;
    cfg_wr_en  = 1'b0;
    if (got < nwords) chk("stream_timeout", got, nwords);
  endtask

  // Check the quiet state after the final handshake of a load.
  task automatic check_done();
    tready = 1'b0;
    chk("done_busy", busy, 0);
    chk("done_valid", tvalid, 0);
    chk("done_count", load_count, exp_loads);
  endtask

  initial begin
    sync_reset  = 1'b1;
    cfg_wr_en   = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    cfg_commit  = 1'b0;
    eob_tag     = 1'b0;
    tready      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_load_count", load_count, 0);
    sync_reset = 1'b0;
    @(negedge clk);

    // Load 1: incrementing pattern, last write shares its cycle with commit
    for (int i = 0; i < MW - 1; i++) wr(i, 32'hA5A5_0000 + 32'(i), 1'b0);
    chk("good_write_no_err", cfg_err, 0);
    wr(MW - 1, 32'hA5A5_0000 + 32'(MW - 1), 1'b1);
    fill_exp();
    arm_and_start();
    run_stream(100, MW, 0);
    exp_loads++;
    check_done();

    // Out-of-range writes are rejected and leave the memory alone
    wr(64, 32'h1111_1111, 1'b0);
    chk("oob64_err_pulse", cfg_err, 1);
    @(negedge clk);
    chk("oob64_err_clear", cfg_err, 0);
    wr(127, 32'h2222_2222, 1'b0);
    chk("oob127_err_pulse", cfg_err, 1);
    @(negedge clk);

    // Load 2: random rewrites, random backpressure, rejected commit mid-stream
    for (int i = 0; i < MW; i++) begin
      if ($urandom_range(0, 1) == 1) wr(i, $urandom, 1'b0);
    end
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    fill_exp();
    arm_and_start();
    run_stream(50, MW, 10);
    exp_loads++;
    check_done();
    repeat (10) @(negedge clk);
    chk("no_second_load_busy", busy, 0);
    chk("no_second_load_count", load_count, exp_loads);

    // Load 3: recommit without writes replays the same mask
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    fill_exp();
    arm_and_start();
    run_stream(70, MW, 0);
    exp_loads++;
    check_done();

`ifdef DSEL_COMMIT_ON_EOB_EN
    // Without eob_tag the controller must wait indefinitely
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    tready = 1'b1;
    repeat (30) @(negedge clk);
    chk("wait_eob_busy", busy, 1);
    chk("wait_eob_no_valid", tvalid, 0);
    eob_tag = 1'b1;
    @(negedge clk);
    eob_tag = 1'b0;
    tready = 1'b0;
    fill_exp();
    run_stream(100, MW, 0);
    exp_loads++;
    check_done();
`endif

    // Reset after word 20 is accepted aborts the load
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    fill_exp();
    arm_and_start();
    run_stream(100, 21, 0);
    tready     = 1'b0;
    sync_reset = 1'b1;
    #1;
    chk("abort_tvalid", tvalid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", load_count, 0);
    exp_loads = 0;
    @(negedge clk);
    sync_reset = 1'b0;
    @(negedge clk);
    chk("abort_stays_quiet", tvalid, 0);

    // Replay after reset starts again from word 0
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    fill_exp();
    arm_and_start();
    run_stream(60, MW, 0);
    exp_loads++;
    check_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/downselect_mask_ctrl.md
DOWNSELECT_MASK_CTRL -- requirements
Module: downselect_mask_ctrl

Interface
REQ-001 SHALL have parameter MASK_WORDS, default 64, number of 32-bit mask words per load (one bit per channel, 2048 channels).
REQ-002 SHALL have parameter ADDR_W, default 6, width of word index; 2**ADDR_W >= MASK_WORDS.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 sync_reset  input  1  asynchronous, active-high reset.
REQ-005 cfg_wr_en  input  1  host write strobe into staging mask memory.
REQ-006 cfg_wr_addr  input  ADDR_W  staging word index.
REQ-007 cfg_wr_data  input  32  mask word; bit b of word w enables channel 32*w+b.
REQ-008 cfg_commit  input  1  single-cycle request to load staging mask into downselect.
REQ-009 eob_tag  input  1  end-of-burst marker from datapath; safe mask-switch point.
REQ-010 m_axis_select_tvalid  output  1  mask word valid toward downselect select port.
REQ-011 m_axis_select_tdata  output  32  mask word.
REQ-012 m_axis_select_tlast  output  1  high on word MASK_WORDS-1.
REQ-013 m_axis_select_tready  input  1  downstream accept.
REQ-014 busy  output  1  high in ARMED or STREAM.
REQ-015 cfg_err  output  1  one-cycle pulse on rejected write or commit.
REQ-016 load_count  output  16  number of completed mask loads, wraps 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE, ARMED, STREAM.
REQ-018 IDLE: cfg_wr_en with cfg_wr_addr < MASK_WORDS writes staging word next edge; addr >= MASK_WORDS dropped, cfg_err pulses next cycle.
REQ-019 IDLE + cfg_commit -> ARMED next cycle; same-cycle cfg_wr_en with commit is written first, included in load.
REQ-020 ARMED -> STREAM on cycle after eob_tag sampled high (see REQ-030).
REQ-021 STREAM: emit words 0..MASK_WORDS-1 in order, one per handshake (tvalid & tready); word 0 valid within 2 cycles of STREAM entry.
REQ-022 tvalid, tdata, tlast SHALL be registered and held stable until handshake; no bubbles required but allowed only while tready low.
REQ-023 tlast high only on word MASK_WORDS-1; its handshake -> IDLE next cycle, load_count += 1, tvalid low.
REQ-024 Writes or commit while busy SHALL be dropped and pulse cfg_err; staging memory unchanged during STREAM.
REQ-025 tready held low indefinitely SHALL stall STREAM with no word lost, duplicated or reordered.
REQ-026 Staging memory contents persist across loads; recommit without writes replays identical mask.

Reset
REQ-027 sync_reset high: state IDLE, m_axis_select_tvalid 0, tdata 0, tlast 0, busy 0, cfg_err 0, load_count 0, word index 0.
REQ-028 Staging memory contents undefined after power-up, not cleared by reset.
REQ-029 Reset mid-STREAM aborts load; no further words emitted; load_count not incremented.

Configuration
REQ-030 Macro DSEL_COMMIT_ON_EOB_EN defined: ARMED waits for eob_tag per REQ-020; undefined: ARMED -> STREAM unconditionally next cycle, eob_tag ignored.

Verification
REQ-031 Write words 0..63 = 0xA5A5_0000+idx, commit, eob_tag pulse at cycle 10, tready=1 -> 64 words in order, tlast on 0xA5A5_003F only, load_count=1, busy low after last.
REQ-032 Same load with tready random 50% -> identical 64-word sequence, tdata stable while tvalid & ~tready.
REQ-033 Write addr 64 in IDLE -> cfg_err one cycle, no memory change; commit during STREAM -> cfg_err, current load unaffected, no second load.
REQ-034 Commit, eob_tag never asserted (macro defined) -> busy stays 1, tvalid stays 0; macro undefined -> streaming begins without eob_tag.
REQ-035 sync_reset asserted after word 20 handshake -> tvalid 0 immediately, load_count 0, next commit replays from word 0.
